// File: rtl/hypot_rr_scheduler.sv
// hypot_rr_scheduler
//   Shares one sequential vector-magnitude engine, floor(sqrt(x^2+y^2)),
//   among NREQ requesters. Requests are picked round-robin through a
//   valid/ready handshake. Each response carries the id of its requester.
//   One cycle squares and sums the operands. A restoring bit-serial
//   square root then produces one result bit per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   ena         global enable; low freezes all state and forces req_ready to 0
//   req_valid   per-requester request valid                 [NREQ]
//   req_ready   per-requester accept, one-hot or zero       [NREQ] (combinational, IDLE only)
//   req_x       packed x operands, requester i at [i*W +: W]
//   req_y       packed y operands, same packing
//   resp_valid  result valid, held until resp_ready
//   resp_ready  result consumed
//   resp_id     requester that owns resp_mag                [IDW]
//   resp_mag    magnitude result                            [W+1]
//   busy        high in every state except IDLE
//
// Configuration
//   HYPOT_ROUND_EN  when defined, resp_mag is rounded to the nearest integer
//                   instead of truncated, with no added latency.

module hypot_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W:0]        resp_mag,
  output logic              busy
);

  localparam int unsigned SW = 2 * W;
  localparam int unsigned RW = 2 * W + 1;
  localparam int unsigned MW = W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic [RW-1:0]   r_rem;
  logic [RW-1:0]   r_root;
  logic [RW-1:0]   r_bit;
  logic [MW-1:0]   r_mag;
  logic            r_resp_valid;
  logic            r_busy;

  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_accept;
  logic [SW-1:0]   w_xx;
  logic [SW-1:0]   w_yy;
  logic [RW-1:0]   w_sum;
  logic [RW-1:0]   w_trial;
  logic            w_ge;
  logic [RW-1:0]   w_rem_step;
  logic [RW-1:0]   w_root_step;
  logic [MW-1:0]   w_root_fin;

  // Round-robin pick: first valid requester at or above the pointer, wrapping
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && req_valid[IDW'((32'(r_ptr) + k) % NREQ)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = IDW'((32'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Next-state and combinational grant
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena && w_gnt_any) begin
          w_accept            = 1'b1;
          req_ready[w_gnt_id] = 1'b1;
          w_state_nxt         = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ena) w_state_nxt = S_ITER;
      end
      S_ITER: begin
        // bit reaches 1 on the final restoring step
        if (ena && r_bit[0]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ena && resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Square-and-sum and one restoring square-root step
  assign w_xx        = SW'(r_x) * SW'(r_x);
  assign w_yy        = SW'(r_y) * SW'(r_y);
  assign w_sum       = RW'(w_xx) + RW'(w_yy);
  assign w_trial     = r_root + r_bit;
  assign w_ge        = (r_rem >= w_trial);
  assign w_rem_step  = w_ge ? (r_rem - w_trial) : r_rem;
  assign w_root_step = w_ge ? ((r_root >> 1) + r_bit) : (r_root >> 1);

`ifdef HYPOT_ROUND_EN
  // rem > root means x^2+y^2 > (root+0.5)^2, so round up
  assign w_root_fin = w_root_step[MW-1:0] + MW'(w_rem_step > w_root_step);
`else
  assign w_root_fin = w_root_step[MW-1:0];
`endif

  // Operand latch, datapath and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_rem        <= '0;
      r_root       <= '0;
      r_bit        <= '0;
      r_mag        <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else if (ena) begin
      r_resp_valid <= (w_state_nxt == S_DONE);
      r_busy       <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x   <= req_x[32'(w_gnt_id) * W +: W];
            r_y   <= req_y[32'(w_gnt_id) * W +: W];
            r_id  <= w_gnt_id;
            r_ptr <= IDW'((32'(w_gnt_id) + 1) % NREQ);
          end
        end
        S_LOAD: begin
          r_rem  <= w_sum;
          r_root <= '0;
          r_bit  <= RW'(1) << SW;
        end
        S_ITER: begin
          r_rem  <= w_rem_step;
          r_root <= w_root_step;
          r_bit  <= r_bit >> 2;
          if (r_bit[0]) r_mag <= w_root_fin;
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_mag   = r_mag;
  assign busy       = r_busy;

endmodule

// File: tb/tb_hypot_rr_scheduler.sv
// Self-checking bench for hypot_rr_scheduler: scoreboard of expected
// (id, magnitude) pairs pushed on each grant and popped on each response,
// plus per-scenario latency, ordering, stall, reset and enable checks.
module tb_hypot_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int MW   = W + 1;

`ifdef HYPOT_ROUND_EN
  localparam int EXP_MAX = 361;
`else
  localparam int EXP_MAX = 360;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W:0]        resp_mag;
  logic              busy;

  logic [W-1:0] opx [NREQ];
  logic [W-1:0] opy [NREQ];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W:0]     mag;
  } exp_t;

  exp_t sb [$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  hypot_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_mag   (resp_mag),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = opx[i];
      req_y[i*W +: W] = opy[i];
    end
  end

  // Reference magnitude by linear search (plus optional round-to-nearest)
  function automatic logic [W:0] model_mag(input int x, input int y);
    int n;
    int m;
    n = x * x + y * y;
    m = 0;
    while ((m + 1) * (m + 1) <= n) m++;
`ifdef HYPOT_ROUND_EN
    if (n - m * m > m) m++;
`endif
    return MW'(m);
  endfunction

  // Scoreboard: push on grant, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst_n && ena) begin
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
          errors++;
          $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
        end else begin
          for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) sb.push_back('{id: IDW'(i), mag: model_mag(int'(opx[i]), int'(opy[i]))});
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: id=%0d mag=%0d with no request outstanding", resp_id, resp_mag);
        end else begin
          e = sb.pop_front();
          if (resp_id !== e.id || resp_mag !== e.mag) begin
            errors++;
            $display("FAIL sb_resp: got id=%0d mag=%0d, want id=%0d mag=%0d", resp_id, resp_mag, e.id, e.mag);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on requester i and waits for its response (resp_ready=1)
  task automatic run_one(input int i, input int x, input int y, output int lat, output int nbusy,
                         output logic [IDW-1:0] id, output logic [W:0] mag, output bit ok);
    int ca;
    bit acc;
    ok = 1'b0; acc = 1'b0; lat = -1; nbusy = 0; ca = 0; id = '0; mag = '0;
    opx[i] = W'(x);
    opy[i] = W'(y);
    req_valid[i] = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (acc && busy) nbusy++;
      if (!acc && req_ready[i]) begin
        acc = 1'b1;
        ca = cyc;
      end else if (acc && resp_valid && resp_ready) begin
        ok = 1'b1;
        lat = cyc - ca;
        id = resp_id;
        mag = resp_mag;
      end
      step();
      if (acc) req_valid[i] = 1'b0;
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== '0 || resp_mag !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b id=%0d mag=%0d busy=%b ready=%b, want all 0",
               resp_valid, resp_id, resp_mag, busy, req_ready);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, resp_valid);
    end
    step();
  endtask

  task automatic test_basic();
    int lat, nb;
    logic [IDW-1:0] id;
    logic [W:0] mag;
    bit ok;
    resp_ready = 1'b1;
    run_one(0, 3, 4, lat, nb, id, mag, ok);
    checks++;
    if (!ok || lat != 11 || id !== 2'd0 || mag !== 9'd5) begin
      errors++;
      $display("FAIL basic_3_4: ok=%b lat=%0d id=%0d mag=%0d, want ok=1 lat=11 id=0 mag=5", ok, lat, id, mag);
    end
    checks++;
    if (nb != 11) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d, want 11", nb);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b after handshake, want 0", busy);
    end
    step();
  endtask

  task automatic test_corners();
    int xs [4] = '{255, 0, 1, 7};
    int ys [4] = '{255, 0, 1, 24};
    int ms [4] = '{EXP_MAX, 0, 1, 25};
    int lat, nb;
    logic [IDW-1:0] id;
    logic [W:0] mag;
    bit ok;
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_one(1, xs[t], ys[t], lat, nb, id, mag, ok);
      checks++;
      if (!ok || id !== 2'd1 || mag !== MW'(ms[t])) begin
        errors++;
        $display("FAIL corner_%0d_%0d: ok=%b id=%0d mag=%0d, want id=1 mag=%0d", xs[t], ys[t], ok, id, mag, ms[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int exp_ord [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
    bit drained;
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) begin
      opx[i] = W'(i + 1);
      opy[i] = W'(2 * i + 3);
    end
    req_valid = '1;
    resp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 300 && order.size() < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) order.push_back(i);
      step();
      if (order.size() >= 4) req_valid = 4'b0101;
    end
    req_valid = '0;
    checks++;
    if (order.size() != 8) begin
      errors++;
      $display("FAIL rr_count: grants=%0d, want 8", order.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (order[j] != exp_ord[j]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, want %0d", j, order[j], exp_ord[j]);
        end
      end
    end
    drained = 1'b0;
    for (int k = 0; k < 40 && !drained; k++) begin
      @(negedge clk);
      if (!busy) drained = 1'b1;
      step();
    end
    checks++;
    if (!drained || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: drained=%b pending=%0d, want 1 0", drained, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit acc, seen;
    acc = 1'b0; seen = 1'b0;
    resp_ready = 1'b0;
    opx[2] = 8'd8; opy[2] = 8'd15;
    req_valid[2] = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[2]) acc = 1'b1;
      if (resp_valid) seen = 1'b1;
      else begin
        step();
        if (acc) req_valid[2] = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout: resp_valid never rose");
    end
    step();
    opx[1] = 8'd9; opy[1] = 8'd12;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_mag !== 9'd17 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b id=%0d mag=%0d ready=%b, want 1 2 17 0000",
                 k, resp_valid, resp_id, resp_mag, req_ready);
      end
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b ready=%b, want 1 0000", resp_valid, req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next_accept: valid=%b ready=%b, want 0 0010", resp_valid, req_ready);
    end
    step();
    req_valid[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_second: second response never arrived");
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int lat, nb;
    logic [IDW-1:0] id;
    logic [W:0] mag;
    bit ok;
    acc = 1'b0;
    resp_ready = 1'b1;
    opx[0] = 8'd3; opy[0] = 8'd4;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (req_ready[0]) acc = 1'b1;
      step();
    end
    req_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== '0 || resp_mag !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL rst_mid: acc=%b valid=%b id=%0d mag=%0d busy=%b ready=%b, want all 0",
               acc, resp_valid, resp_id, resp_mag, busy, req_ready);
    end
    sb.delete();
    step();
    rst_n = 1'b1;
    run_one(3, 6, 8, lat, nb, id, mag, ok);
    checks++;
    if (!ok || lat != 11 || id !== 2'd3 || mag !== 9'd10) begin
      errors++;
      $display("FAIL rst_after: ok=%b lat=%0d id=%0d mag=%0d, want ok=1 lat=11 id=3 mag=10", ok, lat, id, mag);
    end
  endtask

  task automatic test_ena_freeze();
    bit acc, seen;
    int ca, lat;
    acc = 1'b0; seen = 1'b0; ca = 0; lat = -1;
    resp_ready = 1'b1;
    opx[0] = 8'd5; opy[0] = 8'd12;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        acc = 1'b1;
        ca = cyc;
      end
      step();
    end
    req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL ena_freeze_%0d: busy=%b valid=%b ready=%b, want 1 0 0000", k, busy, resp_valid, req_ready);
      end
      step();
    end
    ena = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        lat = cyc - ca;
      end
      step();
    end
    checks++;
    if (!acc || !seen || lat != 15) begin
      errors++;
      $display("FAIL ena_latency: acc=%b seen=%b lat=%0d, want 1 1 15", acc, seen, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opx[i] = '0;
      opy[i] = '0;
    end
    step();
    step();
    test_reset();
    test_basic();
    test_corners();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_ena_freeze();
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected responses never arrived", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
